// File: rtl/core_pkg.sv
// Shared definitions for the kij instruction sequencer that drives `core`.
// Contents:
//   - tile geometry (array columns, pixel and kernel counts, weight base)
//   - bit positions of the 34-bit `core` instruction bus
//   - the idle instruction word: both memories deselected, everything else 0
//   - the sequencer state enum
package core_pkg;

    localparam int COL      = 8;   // array columns = kernel rows per kij
    localparam int LEN_NIJ  = 64;  // input pixels (8x8)
    localparam int LEN_KIJ  = 9;   // kernel positions (3x3)
    localparam int LEN_ONIJ = 36;  // output pixels (6x6)
    localparam int GAP      = 10;  // idle cycles after kernel load / execute
    localparam int IN_W     = 8;   // input image width
    localparam int OUT_W    = 6;   // output image width
    localparam int K_W      = 3;   // kernel width

    localparam logic [10:0] W_BASE = 11'h400;

    localparam int I_ACC      = 33;
    localparam int I_CEN_P    = 32;
    localparam int I_WEN_P    = 31;
    localparam int I_AP_LSB   = 20;
    localparam int I_CEN_X    = 19;
    localparam int I_WEN_X    = 18;
    localparam int I_AX_LSB   = 7;
    localparam int I_OFIFO_RD = 6;
    localparam int I_IFIFO_WR = 5;
    localparam int I_IFIFO_RD = 4;
    localparam int I_L0_RD    = 3;
    localparam int I_L0_WR    = 2;
    localparam int I_EXEC     = 1;
    localparam int I_LOAD     = 0;

    // CEN/WEN high for both memories, all other fields zero.
    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KFETCH,
        S_KLOAD,
        S_GAP1,
        S_AFETCH,
        S_EXEC,
        S_GAP2,
        S_WAITV,
        S_DRAIN,
        S_ACC
    } state_t;

endpackage

// File: rtl/acc_addr_gen.sv
// PMEM read-address generator for the onij accumulation pass.
// Walks kernel taps k = 0..8 for the current output pixel and, on the last
// tap, advances to the next output pixel (column fastest). Row/column
// counters replace the o/6, o%6, k/3, k%3 divides.
// Ports:
//   clk, reset (sync, active-low)
//   clear    - return all counters to pixel 0, tap 0
//   step     - the current address is being issued; advance one tap
//   a_pmem   - k*64 + (orow+ki)*8 + (ocol+kj)
//   last_tap - current tap is k = 8
module acc_addr_gen
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    output logic [10:0] a_pmem,
    output logic        last_tap
);

    logic [2:0] orow;
    logic [2:0] ocol;
    logic [1:0] ki;
    logic [1:0] kj;
    logic [3:0] k;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            orow <= '0;
            ocol <= '0;
            ki   <= '0;
            kj   <= '0;
            k    <= '0;
        end else if (step) begin
            if (last_tap) begin
                k  <= '0;
                ki <= '0;
                kj <= '0;
                if (ocol == 3'(OUT_W - 1)) begin
                    ocol <= '0;
                    orow <= (orow == 3'(OUT_W - 1)) ? 3'd0 : orow + 3'd1;
                end else begin
                    ocol <= ocol + 3'd1;
                end
            end else begin
                k <= k + 4'd1;
                if (kj == 2'(K_W - 1)) begin
                    kj <= '0;
                    ki <= ki + 2'd1;
                end else begin
                    kj <= kj + 2'd1;
                end
            end
        end
    end

    assign last_tap = (k == 4'(LEN_KIJ - 1));
    // Largest value is 8*64 + 7*8 + 7 = 575, fits in 11 bits.
    assign a_pmem = 11'(k) * 11'(LEN_NIJ)
                  + (11'(orow) + 11'(ki)) * 11'(IN_W)
                  + 11'(ocol) + 11'(kj);

endmodule

// File: rtl/kij_sequencer.sv
// Autonomous instruction sequencer for one output tile of `core`.
// For each kij 0..8: kernel fetch, kernel load, gap, activation fetch,
// execute, gap, wait for OFIFO, drain OFIFO to PMEM. Then the onij pass
// reads 9 partial sums per output pixel through the SFP.
// Ports:
//   clk, reset (sync, active-low)
//   start       - one-cycle pulse, honoured only in IDLE
//   ofifo_valid - OFIFO has a full row of results
//   inst        - registered 34-bit `core` instruction bus
//   sfp_clr     - clear SFP accumulator before each output pixel
//   out_valid   - SFP result for out_idx is valid
//   out_idx     - onij index 0..35
//   kij_idx     - current kij 0..8
//   busy        - high outside IDLE
//   done        - one-cycle pulse at tile completion
module kij_sequencer
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        sfp_clr,
    output logic        out_valid,
    output logic [5:0]  out_idx,
    output logic [3:0]  kij_idx,
    output logic        busy,
    output logic        done
);

    state_t      state, state_nx;
    logic [6:0]  cnt, cnt_nx;
    logic [3:0]  kij, kij_nx;
    logic [5:0]  o, o_nx;
    logic [33:0] inst_nx;
    logic        clr_nx, ov_nx, done_nx;
    logic        xrd, prd, ord;
    logic        xrd_p0, prd_p0, ord_p0;
    logic        tap_step;
    logic [10:0] acc_addr;
    logic        last_tap;

    acc_addr_gen u_acc_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == S_IDLE),
        .step     (tap_step),
        .a_pmem   (acc_addr),
        .last_tap (last_tap)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 7'd1;
        kij_nx   = kij;
        o_nx     = o;
        inst_nx  = INST_IDLE;
        clr_nx   = 1'b0;
        ov_nx    = 1'b0;
        done_nx  = 1'b0;
        xrd      = 1'b0;
        prd      = 1'b0;
        ord      = 1'b0;
        tap_step = 1'b0;

        // Memory reads return data a cycle later, so the consumers of a read
        // decided last cycle are issued now.
        inst_nx[I_L0_WR] = xrd_p0;
        inst_nx[I_ACC]   = prd_p0;
        if (ord_p0) begin
            inst_nx[I_CEN_P] = 1'b0;
            inst_nx[I_WEN_P] = 1'b0;
            inst_nx[I_AP_LSB +: 11] = 11'(kij) * 11'(LEN_NIJ) + 11'(cnt) - 11'd1;
        end

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx = S_KFETCH;
                    kij_nx   = '0;
                end
            end
            // One extra cycle at the end lets the final l0_wr land.
            S_KFETCH: begin
                if (cnt < 7'(COL)) begin
                    xrd = 1'b1;
                    inst_nx[I_CEN_X] = 1'b0;
                    inst_nx[I_AX_LSB +: 11] = W_BASE + 11'(kij) * 11'(COL) + 11'(cnt);
                end else begin
                    state_nx = S_KLOAD;
                    cnt_nx   = '0;
                end
            end
            S_KLOAD: begin
                inst_nx[I_L0_RD] = 1'b1;
                inst_nx[I_LOAD]  = 1'b1;
                if (cnt == 7'(2 * COL - 1)) begin
                    state_nx = S_GAP1;
                    cnt_nx   = '0;
                end
            end
            S_GAP1: begin
                if (cnt == 7'(GAP - 1)) begin
                    state_nx = S_AFETCH;
                    cnt_nx   = '0;
                end
            end
            S_AFETCH: begin
                if (cnt < 7'(LEN_NIJ)) begin
                    xrd = 1'b1;
                    inst_nx[I_CEN_X] = 1'b0;
                    inst_nx[I_AX_LSB +: 11] = 11'(cnt);
                end else begin
                    state_nx = S_EXEC;
                    cnt_nx   = '0;
                end
            end
            S_EXEC: begin
                inst_nx[I_L0_RD] = 1'b1;
                inst_nx[I_EXEC]  = 1'b1;
                if (cnt == 7'(LEN_NIJ)) begin
                    state_nx = S_GAP2;
                    cnt_nx   = '0;
                end
            end
            S_GAP2: begin
                if (cnt == 7'(GAP - 1)) begin
                    state_nx = S_WAITV;
                    cnt_nx   = '0;
                end
            end
            // The first OFIFO read is issued in the cycle valid is seen, so
            // DRAIN starts counting at 1.
            S_WAITV: begin
                cnt_nx = '0;
                if (ofifo_valid) begin
                    ord = 1'b1;
                    inst_nx[I_OFIFO_RD] = 1'b1;
                    state_nx = S_DRAIN;
                    cnt_nx   = 7'd1;
                end
            end
            S_DRAIN: begin
                if (cnt < 7'(LEN_NIJ)) begin
                    ord = 1'b1;
                    inst_nx[I_OFIFO_RD] = 1'b1;
                end else begin
                    cnt_nx = '0;
                    if (kij == 4'(LEN_KIJ - 1)) begin
                        state_nx = S_ACC;
                        o_nx     = '0;
                    end else begin
                        state_nx = S_KFETCH;
                        kij_nx   = kij + 4'd1;
                    end
                end
            end
            // Per output pixel: cnt 0 clear, cnt 1 held for the 9 tap reads,
            // cnt 2 last accumulate, cnt 3 result valid.
            S_ACC: begin
                case (cnt)
                    7'd0: clr_nx = 1'b1;
                    7'd1: begin
                        prd      = 1'b1;
                        tap_step = 1'b1;
                        inst_nx[I_CEN_P] = 1'b0;
                        inst_nx[I_AP_LSB +: 11] = acc_addr;
                        cnt_nx = last_tap ? 7'd2 : 7'd1;
                    end
                    7'd2: ;
                    default: begin
                        ov_nx  = 1'b1;
                        cnt_nx = '0;
                        if (o == 6'(LEN_ONIJ - 1)) begin
                            done_nx  = 1'b1;
                            state_nx = S_IDLE;
                            o_nx     = '0;
                            kij_nx   = '0;
                        end else begin
                            o_nx = o + 6'd1;
                        end
                    end
                endcase
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            kij       <= '0;
            o         <= '0;
            xrd_p0    <= 1'b0;
            prd_p0    <= 1'b0;
            ord_p0    <= 1'b0;
            inst      <= INST_IDLE;
            sfp_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            kij       <= kij_nx;
            o         <= o_nx;
            xrd_p0    <= xrd;
            prd_p0    <= prd;
            ord_p0    <= ord;
            inst      <= inst_nx;
            sfp_clr   <= clr_nx;
            out_valid <= ov_nx;
            out_idx   <= o;
            done      <= done_nx;
        end
    end

    assign busy    = (state != S_IDLE);
    assign kij_idx = kij;

endmodule

// File: tb/tb_kij_sequencer.sv
module tb_kij_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        sfp_clr;
    logic        out_valid;
    logic [5:0]  out_idx;
    logic [3:0]  kij_idx;
    logic        busy;
    logic        done;

    kij_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .sfp_clr     (sfp_clr),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .kij_idx     (kij_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [33:0] IDLE_W = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

    // One entry per decision cycle of the tile: bus contents that become
    // visible after the next edge, plus the ofifo_valid stimulus for it.
    typedef struct {
        logic [33:0] inst;
        logic        clr;
        logic        ov;
        logic [5:0]  oidx;
        logic        dn;
        logic [3:0]  kd;
        logic        busy;
        logic [3:0]  kij;
        logic        vld;
    } el_t;

    el_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ov_seen;
    int  done_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push(input logic [33:0] w, input logic clr, input logic ov,
                        input logic [5:0] oi, input logic dn, input logic [3:0] kd,
                        input logic v);
        el_t e;
        e.inst = w; e.clr = clr; e.ov = ov; e.oidx = oi; e.dn = dn;
        e.kd = kd; e.busy = 1'b0; e.kij = 4'd0; e.vld = v;
        exp_q.push_back(e);
    endtask

    function automatic int wait_len(input int k);
        if (k == 2) return 20;
        if (k == 0) return 0;
        return k;
    endfunction

    task automatic build_tile();
        logic [33:0] w;
        int orow, ocol, ki, kj, wl, n;
        exp_q.delete();
        for (int k = 0; k < 9; k++) begin
            wl = wait_len(k);
            for (int t = 0; t <= 8; t++) begin
                w = IDLE_W;
                if (t < 8) begin w[19] = 1'b0; w[17:7] = 11'(1024 + k * 8 + t); end
                if (t >= 1) w[2] = 1'b1;
                push(w, 0, 0, 0, 0, 4'(k), 0);
            end
            for (int t = 0; t < 16; t++) begin
                w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
                push(w, 0, 0, 0, 0, 4'(k), 0);
            end
            for (int t = 0; t < 10; t++) push(IDLE_W, 0, 0, 0, 0, 4'(k), 0);
            for (int t = 0; t <= 64; t++) begin
                w = IDLE_W;
                if (t < 64) begin w[19] = 1'b0; w[17:7] = 11'(t); end
                if (t >= 1) w[2] = 1'b1;
                push(w, 0, 0, 0, 0, 4'(k), 0);
            end
            for (int t = 0; t < 65; t++) begin
                w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
                push(w, 0, 0, 0, 0, 4'(k), 0);
            end
            // When the wait is zero, valid is already high during the gap.
            for (int t = 0; t < 10; t++) push(IDLE_W, 0, 0, 0, 0, 4'(k), (wl == 0));
            for (int t = 0; t < wl; t++) push(IDLE_W, 0, 0, 0, 0, 4'(k), 0);
            for (int t = 0; t <= 64; t++) begin
                w = IDLE_W;
                if (t < 64) w[6] = 1'b1;
                if (t >= 1) begin w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(k * 64 + t - 1); end
                push(w, 0, 0, 0, 0, 4'(k), 1);
            end
        end
        for (int o = 0; o < 36; o++) begin
            orow = o / 6; ocol = o % 6;
            push(IDLE_W, 1, 0, 0, 0, 4'd8, 0);
            for (int j = 0; j <= 9; j++) begin
                w = IDLE_W;
                if (j < 9) begin
                    ki = j / 3; kj = j % 3;
                    w[32] = 1'b0;
                    w[30:20] = 11'(j * 64 + (orow + ki) * 8 + ocol + kj);
                end
                if (j >= 1) w[33] = 1'b1;
                push(w, 0, 0, 0, 0, 4'd8, 0);
            end
            push(IDLE_W, 0, 1, 6'(o), (o == 35), 4'd8, 0);
        end
        // busy/kij_idx are seen alongside the bus word of the previous decision.
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            exp_q[i].busy = (i < n - 1);
            exp_q[i].kij  = (i < n - 1) ? exp_q[i + 1].kd : 4'd0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_inst"}, 64'(inst), 64'(IDLE_W));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_clr"}, 64'(sfp_clr), 64'd0);
        check({tag, "_ov"}, 64'(out_valid), 64'd0);
        check({tag, "_kij"}, 64'(kij_idx), 64'd0);
        check({tag, "_oidx"}, 64'(out_idx), 64'd0);
    endtask

    // Caller is positioned just after a rising edge.
    task automatic run_tile(input int stop_at, input int start_poke, input bit full);
        el_t e;
        int n;
        build_tile();
        ov_seen = 0;
        done_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_kij", 64'(kij_idx), 64'd0);
        check("start_inst", 64'(inst), 64'(IDLE_W));
        n = exp_q.size();
        for (int i = 0; i < n && i < stop_at; i++) begin
            e = exp_q.pop_front();
            ofifo_valid = e.vld;
            start = (i == start_poke);
            @(posedge clk); #1;
            start = 1'b0;
            check("inst", 64'(inst), 64'(e.inst));
            check("sfp_clr", 64'(sfp_clr), 64'(e.clr));
            check("out_valid", 64'(out_valid), 64'(e.ov));
            check("done", 64'(done), 64'(e.dn));
            check("busy", 64'(busy), 64'(e.busy));
            check("kij_idx", 64'(kij_idx), 64'(e.kij));
            if (e.ov) check("out_idx", 64'(out_idx), 64'(e.oidx));
            if (out_valid) ov_seen++;
            if (done) done_seen++;
        end
        ofifo_valid = 1'b0;
        exp_q.delete();
        if (full) begin
            check("ov_count", 64'(ov_seen), 64'd36);
            check("done_count", 64'(done_seen), 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at %0t: got timeout, expected end of test", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        // Abort mid-EXEC of kij 0, then confirm the block stays idle.
        run_tile(120, -1, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle("abort");
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_idle("abort_idle");
        end

        // Full tile from kij 0, with a stray start while busy.
        run_tile(1 << 20, 500, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check_idle("tile_end");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
